mem_arbiter: RTL and testbench

Round-robin arbiter and access sequencer for the 16-bit, 64K-word single-port memory. It sits between NUM_REQ independent requesters and the memory's addr/rd/wr/data pins. It serializes their read and write commands into correctly timed single-word memory cycles and returns read data to the originating requester. The bidirectional data bus is resolved one level up: `data = mem_wr ? mem_wdata : 'z`, and the observed bus value is fed back as `mem_rdata`.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: controller states and the latched command.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   // Wide enough for the largest supported requester count (8).
   localparam int ID_W       = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RWAIT  = 2'd2
   } state_t;

   // Command captured on grant; field widths match the 16-bit, 64K-word memory.
   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [ID_W-1:0]       id;
   } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first active request at or after ptr wins.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   // Walk offsets 0..NUM_REQ-1 from ptr; the first requester hit becomes the one-hot winner.
   always_comb begin
      grant   = '0;
      winner  = '0;
      any_req = 1'b0;
      for (int ofs = 0; ofs < NUM_REQ; ofs++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_req && req[j] && (((int'(ptr) + ofs) % NUM_REQ) == j)) begin
               any_req  = 1'b1;
               grant[j] = 1'b1;
               winner   = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port 16-bit memory.
// Each accepted command becomes one correctly timed memory cycle: writes take
// IDLE->ACCESS, reads take IDLE->ACCESS->RWAIT, and the return to IDLE between
// accesses guarantees bus turnaround before any write drives the data bus.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd,
   output logic                      mem_wr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   cmd_t               cmd;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_winner;
   logic               arb_any;

   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (req),
      .ptr     (ptr),
      .grant   (arb_grant),
      .winner  (arb_winner),
      .any_req (arb_any)
   );

   // Grants are offered only while idle; held at zero throughout reset.
   assign gnt = (state == IDLE && rst_n) ? arb_grant : '0;

   // Address and write data come straight from the command register, so they
   // hold their last values whenever no access is running.
   assign mem_addr  = cmd.addr;
   assign mem_wdata = cmd.wdata;

   // Steer the winning requester's command fields toward the command register.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Controller FSM: latches the winner's command, sequences strobes and returns read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         cmd    <= '0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= '0;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  cmd.we   <= sel_we;
                  cmd.addr <= sel_addr;
                  cmd.id   <= ID_W'(arb_winner);
                  // Reads leave the write data alone so the bus driver value is stable.
                  if (sel_we) begin
                     cmd.wdata <= sel_wdata;
                  end
                  ptr    <= (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
                  mem_wr <= sel_we;
                  mem_rd <= !sel_we;
                  state  <= ACCESS;
               end
            end
            ACCESS: begin
               if (cmd.we) begin
                  mem_wr <= 1'b0;
                  state  <= IDLE;
               end else begin
                  state  <= RWAIT;
               end
            end
            RWAIT: begin
               mem_rd <= 1'b0;
               rdata  <= mem_rdata;
               rvalid <= NUM_REQ'(1) << cmd.id;
               state  <= IDLE;
            end
            default: begin
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: DUT plus a word-addressed memory on a resolved bus,
// and a behavioural model (round-robin pick, access lengths, mirror memory).
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR-1:0]    req_we = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]    gnt;
   logic [NR-1:0]    rvalid;
   logic [DW-1:0]    rdata;
   logic [AW-1:0]    mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [DW-1:0]    mem_wdata;
   logic [DW-1:0]    mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Memory on the shared bus: the arbiter drives while mem_wr, the memory while mem_rd.
   logic [DW-1:0] mem_array [65536] = '{default: '0};
   always @(posedge clk) if (mem_wr) mem_array[mem_addr] <= mem_wdata;
   always_comb mem_rdata = mem_wr ? mem_wdata : (mem_rd ? mem_array[mem_addr] : '0);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model state ----------------
   typedef struct { int id; logic [DW-1:0] data; int due; } rd_exp_t;
   rd_exp_t       rd_q[$];
   logic [DW-1:0] ref_mem [65536] = '{default: '0};
   int            m_ptr = 0, next_free = 0, wr_cyc = -1, rd_cyc0 = -10;
   logic [AW-1:0] wr_addr_e = '0, rd_addr_e = '0, last_wr_addr = '0;
   logic [DW-1:0] wr_data_e = '0;
   int            raise_cyc [NR];
   int            own_free [NR];
   int            last_gnt_cyc [NR];
   int            last_rv_cyc [NR];
   int            gnt_cnt [NR];
   logic [DW-1:0] last_rdata [NR];
   int            dut_log[$];
   int            rv_count = 0, wr_count = 0, last_rd_high = -100, rdwr_gap = 0;
   logic          prev_rd = 1'b0;

   // Model and checks, evaluated on the falling edge away from the active edge.
   always @(negedge clk) begin
      logic [NR-1:0] exp_gnt, exp_rv;
      int w, st, pos;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (!rst_n) begin
         m_ptr = 0; next_free = 0; wr_cyc = -1; rd_cyc0 = -10; prev_rd = 1'b0;
         rd_q.delete();
         for (int i = 0; i < NR; i++) own_free[i] = 0;
      end else begin
         exp_gnt = '0;
         w = -1;
         if (cyc >= next_free) begin
            for (int k = 0; k < NR; k++) begin
               pos = (m_ptr + k) % NR;
               if (w < 0 && req[pos]) w = pos;
            end
         end
         if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            a  = req_addr[w*AW +: AW];
            d  = req_wdata[w*DW +: DW];
            st = (raise_cyc[w] > own_free[w]) ? raise_cyc[w] : own_free[w];
            chk("wait_le_9", 32'((cyc - st) <= 9), 32'd1);
            if (req_we[w]) begin
               ref_mem[a] = d;
               wr_cyc = cyc + 1; wr_addr_e = a; wr_data_e = d;
               next_free = cyc + 2;
            end else begin
               rd_q.push_back('{id: w, data: ref_mem[a], due: cyc + 3});
               rd_cyc0 = cyc + 1; rd_addr_e = a;
               next_free = cyc + 3;
            end
            own_free[w] = next_free;
            m_ptr = (w + 1) % NR;
         end
         chk("gnt", 32'(gnt), 32'(exp_gnt));

         chk("mem_wr", 32'(mem_wr), 32'(cyc == wr_cyc));
         if (cyc == wr_cyc) begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_addr_e));
            chk("wr_data", 32'(mem_wdata), 32'(wr_data_e));
         end
         chk("mem_rd", 32'(mem_rd), 32'((cyc == rd_cyc0) || (cyc == rd_cyc0 + 1)));
         if ((cyc == rd_cyc0) || (cyc == rd_cyc0 + 1)) chk("rd_addr", 32'(mem_addr), 32'(rd_addr_e));
         chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
         chk("turnaround", 32'(prev_rd & mem_wr), 32'd0);

         exp_rv = '0;
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            exp_rv[rd_q[0].id] = 1'b1;
            chk("rdata", 32'(rdata), 32'(rd_q[0].data));
            void'(rd_q.pop_front());
         end
         chk("rvalid", 32'(rvalid), 32'(exp_rv));
      end

      // Observed-activity log used by the directed sections.
      if (mem_wr) begin
         rdwr_gap = cyc - last_rd_high;
         wr_count++;
         last_wr_addr = mem_addr;
      end
      if (mem_rd) last_rd_high = cyc;
      prev_rd = mem_rd;
      for (int i = 0; i < NR; i++) begin
         if (gnt[i]) begin
            gnt_cnt[i]++;
            last_gnt_cyc[i] = cyc;
            dut_log.push_back(i);
         end
         if (rvalid[i]) begin
            last_rdata[i]  = rdata;
            last_rv_cyc[i] = cyc;
            rv_count++;
         end
      end
   end

   // ---------------- stimulus ----------------
   int seen_cnt [NR];

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (gnt_cnt[i] != seen_cnt[i]) begin
            seen_cnt[i] = gnt_cnt[i];
            req[i] = 1'b0;
         end
      end
   endtask

   task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      raise_cyc[i] = cyc;
   endtask

   task automatic wait_quiet(input string tag, input int maxc);
      int n = 0;
      while ((req != '0 || rd_q.size() != 0 || cyc < next_free) && n < maxc) begin
         step();
         n++;
      end
      if (n >= maxc) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic int log_at(input int k);
      return (k < dut_log.size()) ? dut_log[k] : -1;
   endfunction

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         default: return AW'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int wc0, rc0, gl, n, issued;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      rst_n = 1'b1;
      step();

      // Single write then read-back by another requester
      wc0 = wr_count;
      issue(0, 1'b1, 16'h0010, 16'hBEEF);
      wait_quiet("t1w", 20);
      chk("t1_wr_cycles", 32'(wr_count - wc0), 32'd1);
      chk("t1_wr_addr", 32'(last_wr_addr), 32'h0010);
      rc0 = rv_count;
      issue(1, 1'b0, 16'h0010, 16'h0000);
      wait_quiet("t1r", 20);
      chk("t1_rv_count", 32'(rv_count - rc0), 32'd1);
      chk("t1_rdata", 32'(last_rdata[1]), 32'hBEEF);
      chk("t1_latency", 32'(last_rv_cyc[1] - last_gnt_cyc[1]), 32'd3);

      // Both requesters reading continuously: grants alternate starting at 0
      gl = dut_log.size();
      issue(0, 1'b0, pick_addr(), '0);
      issue(1, 1'b0, pick_addr(), '0);
      n = 0;
      while (dut_log.size() < gl + 8 && n < 60) begin
         step();
         n++;
         for (int i = 0; i < 2; i++) if (!req[i]) issue(i, 1'b0, pick_addr(), '0);
      end
      wait_quiet("t2", 20);
      for (int k = 0; k < 8; k++) chk("t2_order", 32'(log_at(gl + k)), 32'(k % 2));

      // ptr=1: write by req1 and read by req0 of 16'hFFFF in the same cycle
      issue(0, 1'b0, 16'h0020, '0);
      wait_quiet("t3a", 20);
      gl = dut_log.size();
      issue(1, 1'b1, 16'hFFFF, 16'h1234);
      issue(0, 1'b0, 16'hFFFF, '0);
      wait_quiet("t3b", 20);
      chk("t3_first", 32'(log_at(gl)), 32'd1);
      chk("t3_second", 32'(log_at(gl + 1)), 32'd0);
      chk("t3_rdata", 32'(last_rdata[0]), 32'h1234);

      // Read immediately followed by a write: an idle bus cycle separates them
      gl = dut_log.size();
      issue(1, 1'b0, 16'h0005, '0);
      issue(0, 1'b1, 16'h0006, 16'hA5A5);
      wait_quiet("t4", 20);
      chk("t4_first", 32'(log_at(gl)), 32'd1);
      chk("t4_second", 32'(log_at(gl + 1)), 32'd0);
      chk("t4_gap_ge2", 32'(rdwr_gap >= 2), 32'd1);

      // Reset during RWAIT aborts the read; grants restart at requester 0
      gl = dut_log.size();
      issue(2, 1'b0, 16'h0010, '0);
      n = 0;
      while (dut_log.size() == gl && n < 10) begin
         step();
         n++;
      end
      if (n >= 10) chk("t5_gnt_timeout", 32'd0, 32'd1);
      step();
      for (int i = 0; i < NR; i++) issue(i, 1'b0, 16'(16'h0040 + i), '0);
      rc0 = rv_count;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_gnt", 32'(gnt), 32'd0);
      chk("t5_rvalid", 32'(rvalid), 32'd0);
      chk("t5_rdata", 32'(rdata), 32'd0);
      chk("t5_mem_rd", 32'(mem_rd), 32'd0);
      chk("t5_mem_wr", 32'(mem_wr), 32'd0);
      chk("t5_mem_addr", 32'(mem_addr), 32'd0);
      chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("t5_no_rvalid", 32'(rv_count - rc0), 32'd0);
      gl = dut_log.size();
      for (int i = 0; i < NR; i++) issue(i, 1'b0, 16'(16'h0040 + i), '0);
      n = 0;
      while (dut_log.size() < gl + 5 && n < 60) begin
         step();
         n++;
         for (int i = 0; i < NR; i++) if (!req[i]) issue(i, 1'b0, pick_addr(), '0);
      end
      wait_quiet("t5", 40);
      for (int k = 0; k < 5; k++) chk("t5_order", 32'(log_at(gl + k)), 32'(k % NR));

      // Random mixed traffic from all requesters against the model
      issued = 0;
      n = 0;
      while ((issued < 10000 || req != '0 || rd_q.size() != 0) && n < 80000) begin
         step();
         n++;
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && issued < 10000 && $urandom_range(0, 2) == 0) begin
               issue(i, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
               issued++;
            end
         end
      end
      if (n >= 80000) chk("t6_timeout", 32'd0, 32'd1);
      wait_quiet("t6", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
